// File: rtl/frame_sequencer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : frame_sequencer
// Description : APU frame counter producing quarter/half-frame enables and
//               the level frame IRQ; configured by synchronised $4017 writes.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_sequencer #(
    parameter int STEP1       = 7457,
    parameter int STEP2       = 14913,
    parameter int STEP3       = 22371,
    parameter int STEP4       = 29829,
    parameter int STEP5       = 37281,
    parameter int WRITE_DELAY = 3,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] reg_4017,
    input  logic       reg_change,
    input  logic       irq_ack,
    output logic       quarter_frame,
    output logic       half_frame,
    output logic       frame_irq,
    output logic       mode_5step
);

    localparam logic [CNT_W-1:0] c_step1 = CNT_W'(STEP1);
    localparam logic [CNT_W-1:0] c_step2 = CNT_W'(STEP2);
    localparam logic [CNT_W-1:0] c_step3 = CNT_W'(STEP3);
    localparam logic [CNT_W-1:0] c_step4 = CNT_W'(STEP4);
    localparam logic [CNT_W-1:0] c_step5 = CNT_W'(STEP5);
    localparam logic [2:0]       c_delay = 3'(WRITE_DELAY);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } wr_state_t;

    wr_state_t        r_state;
    wr_state_t        w_state_next;

    logic [2:0]       r_chg_sync;
    logic [2:0]       r_ack_sync;
    logic [1:0]       r_arm;
    logic             r_write_event;
    logic             r_ack_event;

    logic             r_pending_mode;
    logic             r_inhibit;
    logic [2:0]       r_delay;
    logic             r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic             r_quarter;
    logic             r_half;
    logic             r_irq;

    logic             w_active;
    logic [2:0]       w_delay_cur;
    logic [2:0]       w_delay_next;
    logic             w_restart;
    logic             w_new_mode;
    logic             w_at_s1;
    logic             w_at_s2;
    logic             w_at_s3;
    logic             w_at_s4;
    logic             w_at_s5;
    logic             w_last_step;
    logic             w_q_step;
    logic             w_h_step;
    logic             w_irq_set;
    logic             w_irq_clr;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_quarter_next;
    logic             w_half_next;
    logic             w_irq_next;
    logic             w_unused;

    assign w_unused = ^reg_4017[5:0];

    // Edge detection is held off until the synchronisers have been refilled
    // after reset, so a toggle level left over from before reset is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chg_sync    <= 3'b000;
            r_ack_sync    <= 3'b000;
            r_arm         <= 2'd0;
            r_write_event <= 1'b0;
            r_ack_event   <= 1'b0;
        end else begin
            r_chg_sync    <= {r_chg_sync[1:0], reg_change};
            r_ack_sync    <= {r_ack_sync[1:0], irq_ack};
            if (r_arm != 2'd3) begin
                r_arm <= r_arm + 2'd1;
            end
            r_write_event <= (r_arm == 2'd3) && (r_chg_sync[1] != r_chg_sync[2]);
            r_ack_event   <= (r_arm == 2'd3) && (r_ack_sync[1] != r_ack_sync[2]);
        end
    end

    // The write-event clock counts as the first of the WRITE_DELAY clocks;
    // a new write while one is pending simply restarts the countdown.
    always_comb begin
        w_active     = r_write_event || (r_state == ST_PENDING);
        w_delay_cur  = r_write_event ? c_delay : r_delay;
        w_restart    = w_active && (w_delay_cur == 3'd1);
        w_delay_next = w_active ? (w_delay_cur - 3'd1) : r_delay;
        w_new_mode   = r_write_event ? reg_4017[7] : r_pending_mode;

        w_state_next = r_state;
        if (w_restart) begin
            w_state_next = ST_IDLE;
        end else if (r_write_event) begin
            w_state_next = ST_PENDING;
        end
    end

    always_comb begin
        w_at_s1     = (r_cnt == c_step1);
        w_at_s2     = (r_cnt == c_step2);
        w_at_s3     = (r_cnt == c_step3);
        w_at_s4     = (r_cnt == c_step4);
        w_at_s5     = (r_cnt == c_step5);
        w_last_step = r_mode ? w_at_s5 : w_at_s4;
        w_q_step    = w_at_s1 || w_at_s2 || w_at_s3 || w_last_step;
        w_h_step    = w_at_s2 || w_last_step;
        w_irq_set   = w_at_s4 && !r_mode && !r_inhibit && !w_restart;
        w_irq_clr   = r_ack_event || (r_write_event && reg_4017[6]);

        w_cnt_next     = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        w_quarter_next = w_q_step;
        w_half_next    = w_h_step;
        if (w_restart) begin
            // A restart overrides any step decode landing on the same clock.
            w_cnt_next     = '0;
            w_quarter_next = w_new_mode;
            w_half_next    = w_new_mode;
        end else if (w_last_step) begin
            w_cnt_next = '0;
        end

        w_irq_next = r_irq;
        if (w_irq_set) begin
            w_irq_next = 1'b1;
        end else if (w_irq_clr) begin
            w_irq_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_pending_mode <= 1'b0;
            r_inhibit      <= 1'b0;
            r_delay        <= 3'd0;
            r_mode         <= 1'b0;
            r_cnt          <= '0;
            r_quarter      <= 1'b0;
            r_half         <= 1'b0;
            r_irq          <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_delay   <= w_delay_next;
            r_cnt     <= w_cnt_next;
            r_quarter <= w_quarter_next;
            r_half    <= w_half_next;
            r_irq     <= w_irq_next;
            if (r_write_event) begin
                r_pending_mode <= reg_4017[7];
                r_inhibit      <= reg_4017[6];
            end
            if (w_restart) begin
                r_mode <= w_new_mode;
            end
        end
    end

    assign quarter_frame = r_quarter;
    assign half_frame    = r_half;
    assign frame_irq     = r_irq;
    assign mode_5step    = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_frame_sequencer
// Description : Scoreboard bench for frame_sequencer with shortened step indices.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_sequencer;

    localparam int S1   = 30;
    localparam int S2   = 61;
    localparam int S3   = 95;
    localparam int S4   = 130;
    localparam int S5   = 171;
    localparam int WD   = 3;
    localparam int P4   = S4 + 1;
    localparam int P5   = S5 + 1;
    localparam int NPER = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] reg_4017 = 8'h00;
    logic       reg_change = 1'b0;
    logic       irq_ack = 1'b0;
    logic       quarter_frame;
    logic       half_frame;
    logic       frame_irq;
    logic       mode_5step;

    frame_sequencer #(
        .STEP1      (S1),
        .STEP2      (S2),
        .STEP3      (S3),
        .STEP4      (S4),
        .STEP5      (S5),
        .WRITE_DELAY(WD),
        .CNT_W      (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reg_4017     (reg_4017),
        .reg_change   (reg_change),
        .irq_ack      (irq_ack),
        .quarter_frame(quarter_frame),
        .half_frame   (half_frame),
        .frame_irq    (frame_irq),
        .mode_5step   (mode_5step)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int gen;
        bit q;
        bit h;
        bit irq;
    } ev_t;

    ev_t sb[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  gen = 0;
    int  pend_gen = -1;
    int  pend_rc = -1;
    bit  pend_mode = 1'b0;
    int  act_base = 0;
    bit  exp_irq = 1'b0;
    bit  exp_inh = 1'b0;
    bit  exp_mode = 1'b0;
    int  ack_clr = -1;
    int  wr_clr = -1;
    int  cap_cyc = -1;
    bit  cap_inh = 1'b0;
    bit  mon_en = 1'b0;
    bit  m_q;
    bit  m_h;
    bit  m_s;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input int g, input bit q, input bit h, input bit irq);
        ev_t e;
        e.cyc = c; e.gen = g; e.q = q; e.h = h; e.irq = irq;
        sb.push_back(e);
    endtask

    // Expected pulses for a sequence whose counter reads 0 in cycle 'base'.
    task automatic push_plan(input int base, input bit m5, input int g);
        int p;
        if (m5) push_ev(base, g, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < NPER; k++) begin
            p = base + k * (m5 ? P5 : P4);
            push_ev(p + S1 + 1, g, 1'b1, 1'b0, 1'b0);
            push_ev(p + S2 + 1, g, 1'b1, 1'b1, 1'b0);
            push_ev(p + S3 + 1, g, 1'b1, 1'b0, 1'b0);
            if (m5) push_ev(p + S5 + 1, g, 1'b1, 1'b1, 1'b0);
            else    push_ev(p + S4 + 1, g, 1'b1, 1'b1, 1'b1);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            m_q = 1'b0; m_h = 1'b0; m_s = 1'b0;
            if (cyc == pend_rc) begin
                for (int i = sb.size() - 1; i >= 0; i--)
                    if (sb[i].gen != pend_gen) sb.delete(i);
                exp_mode = pend_mode;
                act_base = pend_rc;
                pend_rc  = -1;
            end
            for (int i = 0; i < sb.size(); i++) begin
                if (sb[i].cyc == cyc) begin
                    m_q = sb[i].q; m_h = sb[i].h; m_s = sb[i].irq;
                    sb.delete(i);
                    break;
                end
            end
            if (cyc == ack_clr || cyc == wr_clr) exp_irq = 1'b0;
            if (m_s && !exp_inh) exp_irq = 1'b1;
            if (cyc == cap_cyc) exp_inh = cap_inh;
            check("pulse_qh", {30'd0, quarter_frame, half_frame}, {30'd0, m_q, m_h});
            check("frame_irq", {31'd0, frame_irq}, {31'd0, exp_irq});
            check("mode_5step", {31'd0, mode_5step}, {31'd0, exp_mode});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic write_reg(input logic [7:0] val);
        int t;
        t = cyc;
        reg_4017   = val;
        reg_change = ~reg_change;
        cap_cyc = t + 4;
        cap_inh = val[6];
        if (val[6]) wr_clr = t + 4;
        if (pend_rc > cyc) begin
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].gen == pend_gen) sb.delete(i);
        end
        gen++;
        pend_gen  = gen;
        pend_rc   = t + 3 + WD;
        pend_mode = val[7];
        push_plan(pend_rc, val[7], gen);
    endtask

    task automatic ack_irq();
        irq_ack = ~irq_ack;
        ack_clr = cyc + 4;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        check("rst_quarter", {31'd0, quarter_frame}, 32'd0);
        check("rst_half", {31'd0, half_frame}, 32'd0);
        check("rst_irq", {31'd0, frame_irq}, 32'd0);
        check("rst_mode", {31'd0, mode_5step}, 32'd0);
        sb.delete();
        pend_rc = -1; ack_clr = -1; wr_clr = -1; cap_cyc = -1;
        exp_irq = 1'b0; exp_inh = 1'b0; exp_mode = 1'b0;
        mon_en = 1'b1;
        tick(n);
        rst_n = 1'b1;
        gen++;
        act_base = cyc;
        push_plan(cyc, 1'b0, gen);
    endtask

    initial begin
        #1;
        // Reset release, free-running 4-step sequence over two periods.
        do_reset(3);
        tick(2 * P4 + S1 + 10);
        check("irq_after_step4", {31'd0, frame_irq}, 32'd1);

        // Acknowledge clears the IRQ; it sets again at the next step 4.
        ack_irq();
        tick(4);
        check("irq_acked", {31'd0, frame_irq}, 32'd0);
        tick(P4 + 5);
        check("irq_reset_again", {31'd0, frame_irq}, 32'd1);

        // Inhibit write clears the IRQ and keeps it low for three frames.
        write_reg(8'h40);
        tick(4);
        check("irq_inhibited", {31'd0, frame_irq}, 32'd0);
        tick(3 * P4 + 20);
        check("irq_stays_low", {31'd0, frame_irq}, 32'd0);

        // 5-step mode with immediate pulses and no IRQ.
        write_reg(8'h80);
        tick(2 * P5 + S1 + 10);
        check("mode5_applied", {31'd0, mode_5step}, 32'd1);

        // Back-to-back writes give one restart timed from the second.
        write_reg(8'h80);
        tick(2);
        write_reg(8'h00);
        tick(2 * P4 + 20);
        check("mode4_applied", {31'd0, mode_5step}, 32'd0);

        // Reset while a write is pending, near step 2.
        while (cyc < act_base + S2 - 3) tick(1);
        write_reg(8'h80);
        tick(2);
        do_reset(1);
        tick(P4 + S2 + 10);
        check("no_restart_after_rst", {31'd0, mode_5step}, 32'd0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
APU frame counter that schedules the envelope, linear-counter, length-counter and sweep clocks for all channels. It is driven by the 1.79 MHz APU clock and configured by CPU writes to $4017, which arrive through a toggle-based clock crossing. It produces single-cycle quarter-frame (~240 Hz) and half-frame (~120 Hz) enables, runs in 4-step or 5-step mode, and raises a level frame IRQ.

Parameters:
STEP1, 7457, cycle index of step 1 (quarter frame)
STEP2, 14913, cycle index of step 2 (quarter and half frame)
STEP3, 22371, cycle index of step 3 (quarter frame)
STEP4, 29829, cycle index of step 4 (4-step: quarter, half and IRQ; 5-step: nothing)
STEP5, 37281, cycle index of step 5 (5-step mode only: quarter and half frame)
WRITE_DELAY, 3, clocks from the detected $4017 write to the sequence restart (1..7)
CNT_W, 16, cycle counter width; must hold STEP5

Ports:
clk  in  1  APU clock, 1.79 MHz
rst_n  in  1  asynchronous active-low reset
reg_4017  in  8  $4017 value; bit7 = mode (1 = 5-step), bit6 = IRQ inhibit; stable when reg_change toggles
reg_change  in  1  toggles once per $4017 write; asynchronous to clk
irq_ack  in  1  toggles once per $4015 read; asynchronous to clk
quarter_frame  out  1  one-clock enable, drives enable_240hz of the channels
half_frame  out  1  one-clock enable for length counters and sweep
frame_irq  out  1  level frame interrupt
mode_5step  out  1  currently applied mode, for debug

Behaviour:
- Reset (async, rst_n = 0): cycle counter = 0; mode_5step = 0; inhibit = 0; frame_irq = 0; quarter_frame = 0; half_frame = 0; write pending cleared; synchroniser flops = 0. Release must not produce an edge event.
- Synchronisers: reg_change and irq_ack each pass through 2 flops, followed by a registered edge detect (new != old). This gives a write_event or ack_event pulse 3 clocks after the input toggle.
- On write_event: capture reg_4017[7:6] into pending_mode and inhibit, and load the delay counter with WRITE_DELAY. Inhibit takes effect immediately: if inhibit = 1, frame_irq clears on the next clock.
- If a second write_event arrives while a write is pending, recapture the data and reload the delay counter. Only one restart occurs.
- Restart: when the delay counter reaches 0, set the cycle counter to 0 and load mode_5step from pending_mode.
  - If the new mode is 5-step, pulse quarter_frame and half_frame on that same clock.
  - If the new mode is 4-step, no pulse.
  - Any step decode that coincides with the restart clock is suppressed.
- Cycle counter: increments by 1 each clock.
  - 4-step mode: wraps to 0 on the clock after it equals STEP4, giving a period of STEP4+1.
  - 5-step mode: wraps at STEP5, giving a period of STEP5+1.
- Outputs are registered and are 1 for exactly one clock, on the clock after the counter equals the step index:
  - quarter_frame at STEP1, STEP2, STEP3, and STEP4 (4-step) or STEP5 (5-step).
  - half_frame at STEP2, and STEP4 (4-step) or STEP5 (5-step).
  - 5-step mode produces no output at STEP4.
- frame_irq:
  - Set (level) at STEP4 in 4-step mode when inhibit = 0.
  - Cleared by ack_event, by a write_event with inhibit = 1, or by reset.
  - Set and clear on the same clock: set wins.
  - Never set in 5-step mode.
- No output pulses occur while rst_n = 0. Asserting reset mid-write drops the pending write.

Test Plan:
1. Reset release, no writes. Required: quarter_frame pulses after counter values 7457, 14913, 22371 and 29829; half_frame after 14913 and 29829; frame_irq rises with the 29829 pulse; the pattern repeats with a period of 29830.
2. Write 0x80 (toggle reg_change). Required: restart 3+WRITE_DELAY clocks after the toggle, with quarter_frame and half_frame both pulsing on the restart clock; then quarter at steps 1, 2, 3 and 5, none at 29829, period 37282; frame_irq stays 0.
3. With frame_irq = 1, toggle irq_ack. Required: frame_irq = 0 four clocks after the toggle; it sets again at the next STEP4.
4. Write 0x40 while frame_irq = 1. Required: frame_irq clears one clock after write_event and stays 0 across the next three STEP4 events.
5. Write 0x80, then 0x00 two clocks later. Required: a single restart, timed from the second write, in 4-step mode with no immediate pulses.
6. Assert rst_n low for 1 clock while a write is pending and the counter is near STEP2. Required: all outputs are 0 immediately, no restart pulse follows, and the counter restarts from 0 in 4-step mode.
